seq_divider8: RTL and testbench
===============================

Name: seq_divider8

Overview:
- Sequential unsigned restoring divider; the inverse datapath of the team's shift-add multiplier.
- Computes Quotient = Dividend / Divisor and Remainder = Dividend mod Divisor, one bit per SHIFT/SUB state pair.
- Sits beside the multiplier in the processor top level, fed from the synchronized switches and button.
- Results drive the existing hex display drivers.

Parameters:
- WIDTH, 8, operand, quotient and remainder width.
- CNT_W, 3, iteration counter width; equals clog2(WIDTH).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  synchronized, active-high, level-sensitive run request.
- Dividend  in  WIDTH  numerator; sampled only on the start edge.
- Divisor  in  WIDTH  denominator; sampled only on the start edge.
- Quotient  out  WIDTH  working/result quotient register.
- Remainder  out  WIDTH  working/result remainder, low WIDTH bits of R.
- Busy  out  1  high in SHIFT and SUB states.
- Done  out  1  high in DONE state.
- DivZero  out  1  sticky flag: last run had Divisor == 0.

Behaviour:
- Reset (async) sets state = IDLE and clears every register to 0: R(9b), Q, D, count, Quotient, Remainder, Busy, Done, DivZero.
- States: IDLE, SHIFT, SUB, DONE.
- IDLE, Start=1, Divisor!=0:
  - R<=0, Q<=Dividend, D<=Divisor, count<=0, DivZero<=0.
  - Next state SHIFT.
- IDLE, Start=1, Divisor==0:
  - Q<=8'hFF, R<=Dividend, DivZero<=1.
  - Next state DONE. Done is visible 1 cycle after the sampling edge.
- IDLE, Start=0: hold state; registers unchanged, so the previous results stay displayed.
- SHIFT: {R,Q} <= {R,Q} << 1, with 0 shifted into Q[0]. Next state SUB.
- SUB: diff = R - {1'b0,D} in 10-bit arithmetic.
  - diff >= 0: R<=diff[8:0], Q[0]<=1.
  - diff < 0: R unchanged, Q[0] stays 0.
  - count == WIDTH-1: next state DONE.
  - Otherwise: count<=count+1, next state SHIFT.
- Width rule: R is 9 bits internally. Invariant R < D before each SHIFT, so the shifted R is at most 2D-1 <= 509. The 9th bit is always 0 in DONE.
- Latency: Done asserts 2*WIDTH = 16 edges after the Start-sampling edge. Busy is high for exactly 16 cycles.
- DONE: outputs are stable and Done=1. Stays in DONE while Start=1, so a held button never retriggers. Start=0 moves to IDLE.
- Start falling during SHIFT/SUB is ignored; the run completes.
- Dividend/Divisor changes after the sampling edge have no effect on the run in progress.
- Reset mid-operation aborts immediately to IDLE with all outputs 0. After Reset deasserts, Start=1 starts a new run on the next edge.
- Quotient/Remainder are driven directly from Q and R[7:0]. Their values are guaranteed only when Done=1.
- Count wraps 7->0 only via reload in IDLE; it is never incremented in DONE.

Decomposition:
- Package div_pkg holds:
  - the typedef enum logic [1:0] div_state_t {IDLE, SHIFT, SUB, DONE};
  - localparam DIV_WIDTH = 8 and DIV_CNT_W = 3.
- Sub-module div_datapath holds the R/Q/D registers, the 10-bit subtractor and the shift logic.
  - Controls in: load, load_zero, shift, sub.
  - Status out: count_last.
- seq_divider8 keeps the FSM and the counter.

Test Plan:
- 200/7, Start pulse held 3 cycles then released:
  - Busy high for 16 cycles, then Done=1, Quotient=28 (8'h1C), Remainder=4, DivZero=0.
  - After release, returns to IDLE and holds the results.
- 255/1 -> Quotient=255, Remainder=0. Then 1/255 -> Quotient=0, Remainder=1. Done exactly 16 edges after start each time.
- 5/9 (dividend < divisor) -> Quotient=0, Remainder=5. Then 144/12 -> Quotient=12, Remainder=0.
- 77/0 -> Done 1 cycle after start, DivZero=1, Quotient=8'hFF, Remainder=77, Busy never high.
  - A following run of 9/3 clears DivZero and gives Quotient=3, Remainder=0.
- Reset mid-run:
  - Start 200/7, assert Reset asynchronously (mid-cycle) at cycle 6 -> state IDLE and all outputs 0 immediately.
  - Release Reset with Start=1 and 100/10 -> Quotient=10, Remainder=0 after 16 cycles.
- Start held high through DONE for 20 cycles -> no second run and Busy stays 0.
  - Change Dividend during this time -> results unchanged.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: partial remainder R (WIDTH+1 bits), quotient Q,
// divisor D, and the trial subtractor. The FSM in seq_divider8 sequences the controls.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_load_zero,
    input  logic             i_shift,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic [CNT_W-1:0] i_count,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_count_last
);

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH+1:0] w_diff;

    // One extra bit beyond R so the sign of R - D is the MSB of the difference.
    assign w_diff       = {1'b0, r_rem} - {2'b00, r_den};
    assign o_count_last = (i_count == CNT_W'(WIDTH - 1));
    assign o_quotient   = r_quo;
    assign o_remainder  = r_rem[WIDTH-1:0];

    // NOTE: registers use non-blocking assignments so every update in a cycle reads pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_den <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_den <= i_divisor;
        end else if (i_load_zero) begin
            r_rem <= {1'b0, i_dividend};
            r_quo <= '1;
        end else if (i_shift) begin
            // R < D before the shift, so the dropped R[WIDTH] is always zero.
            {r_rem, r_quo} <= {r_rem[WIDTH-1:0], r_quo, 1'b0};
        end else if (i_sub && !w_diff[WIDTH+1]) begin
            r_rem    <= w_diff[WIDTH:0];
            r_quo[0] <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider8.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB pair,
// divide-by-zero short-circuits to DONE with Quotient=all-ones, Remainder=Dividend.
module seq_divider8
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;

    logic w_start;
    logic w_load;
    logic w_load_zero;
    logic w_shift;
    logic w_sub;
    logic w_count_last;

    assign w_start     = (r_state == IDLE) && Start;
    assign w_load      = w_start && (Divisor != '0);
    assign w_load_zero = w_start && (Divisor == '0);
    assign w_shift     = (r_state == SHIFT);
    assign w_sub       = (r_state == SUB);

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign DivZero = r_divzero;

    div_datapath #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_datapath (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_load       (w_load),
        .i_load_zero  (w_load_zero),
        .i_shift      (w_shift),
        .i_sub        (w_sub),
        .i_dividend   (Dividend),
        .i_divisor    (Divisor),
        .i_count      (r_count),
        .o_quotient   (Quotient),
        .o_remainder  (Remainder),
        .o_count_last (w_count_last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state   <= SHIFT;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_divzero <= 1'b0;
                    end else if (w_load_zero) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_divzero <= 1'b1;
                    end
                end
                SHIFT: r_state <= SUB;
                SUB: begin
                    if (w_count_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                        r_state <= SHIFT;
                    end
                end
                DONE: begin
                    // A held Start parks here so one press yields exactly one run.
                    if (!Start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: arithmetic reference model compared every
// cycle, plus directed runs with hand-computed quotient, remainder and latency.
module tb_seq_divider8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Dividend = '0;
    logic [7:0] Divisor = '0;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider8 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is "busy for 16 cycles, then show a/b and a%b".
    typedef enum {M_IDLE, M_RUN, M_DONE} m_mode_t;
    m_mode_t    m_mode  = M_IDLE;
    int         m_left  = 0;
    logic [7:0] m_q     = '0;
    logic [7:0] m_r     = '0;
    logic       m_dz    = 1'b0;
    bit         m_valid = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_mode  = M_IDLE;
            m_left  = 0;
            m_q     = '0;
            m_r     = '0;
            m_dz    = 1'b0;
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (Start && Divisor == 8'd0) begin
                        m_mode = M_DONE;
                        m_q    = 8'hFF;
                        m_r    = Dividend;
                        m_dz   = 1'b1;
                    end else if (Start) begin
                        m_mode = M_RUN;
                        m_left = 16;
                        m_q    = Dividend / Divisor;
                        m_r    = Dividend % Divisor;
                        m_dz   = 1'b0;
                    end
                end
                M_RUN: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_DONE;
                end
                M_DONE: if (!Start) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            check("busy", {31'd0, Busy}, {31'd0, m_mode == M_RUN});
            check("done", {31'd0, Done}, {31'd0, m_mode == M_DONE});
            check("divzero", {31'd0, DivZero}, {31'd0, m_dz});
            if (m_mode != M_RUN) begin
                check("quotient", {24'd0, Quotient}, {24'd0, m_q});
                check("remainder", {24'd0, Remainder}, {24'd0, m_r});
            end
        end
    end

    task automatic start_run(input logic [7:0] a, input logic [7:0] b);
        @(posedge Clk);
        #2;
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
    endtask

    // hold == 0 keeps Start high after Done; otherwise Start drops after 'hold' edges.
    task automatic wait_result(input string name, input int q, input int r, input int dz,
                               input int edges, input int busy_cycles, input int hold);
        int n = 0;
        int nb = 0;
        while (n < 40 && Done !== 1'b1) begin
            @(posedge Clk);
            #1;
            n++;
            if (Busy === 1'b1) nb++;
            if (hold != 0 && n == hold) Start = 1'b0;
        end
        check({name, " done"}, {31'd0, Done}, 32'd1);
        check({name, " latency"}, n, edges);
        check({name, " busy cycles"}, nb, busy_cycles);
        check({name, " q"}, {24'd0, Quotient}, q);
        check({name, " r"}, {24'd0, Remainder}, r);
        check({name, " divzero"}, {31'd0, DivZero}, dz);
        if (hold != 0) Start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        @(negedge Clk);
        check("reset q", {24'd0, Quotient}, 0);
        check("reset r", {24'd0, Remainder}, 0);
        check("reset busy", {31'd0, Busy}, 0);
        check("reset done", {31'd0, Done}, 0);
        check("reset divzero", {31'd0, DivZero}, 0);

        start_run(8'd200, 8'd7);
        wait_result("200/7", 28, 4, 0, 17, 16, 3);
        repeat (2) @(posedge Clk);
        #1;
        check("idle done", {31'd0, Done}, 0);
        check("idle held q", {24'd0, Quotient}, 28);
        check("idle held r", {24'd0, Remainder}, 4);

        start_run(8'd255, 8'd1);
        wait_result("255/1", 255, 0, 0, 17, 16, 1);
        start_run(8'd1, 8'd255);
        wait_result("1/255", 0, 1, 0, 17, 16, 1);
        start_run(8'd5, 8'd9);
        wait_result("5/9", 0, 5, 0, 17, 16, 1);
        start_run(8'd144, 8'd12);
        wait_result("144/12", 12, 0, 0, 17, 16, 1);
        start_run(8'd77, 8'd0);
        wait_result("77/0", 255, 77, 1, 1, 0, 1);
        start_run(8'd9, 8'd3);
        wait_result("9/3", 3, 0, 0, 17, 16, 1);

        // Asynchronous reset in the middle of a run.
        start_run(8'd200, 8'd7);
        repeat (6) @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        check("abort q", {24'd0, Quotient}, 0);
        check("abort r", {24'd0, Remainder}, 0);
        check("abort busy", {31'd0, Busy}, 0);
        check("abort done", {31'd0, Done}, 0);
        check("abort divzero", {31'd0, DivZero}, 0);
        Dividend = 8'd100;
        Divisor  = 8'd10;
        Start    = 1'b1;
        @(posedge Clk);
        #2 Reset = 1'b0;
        wait_result("100/10", 10, 0, 0, 17, 16, 1);

        // Start held through DONE must not retrigger; input changes are ignored.
        start_run(8'd50, 8'd6);
        wait_result("50/6", 8, 2, 0, 17, 16, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (i == 10) Dividend = 8'd201;
            check("held busy", {31'd0, Busy}, 0);
            check("held done", {31'd0, Done}, 1);
            check("held q", {24'd0, Quotient}, 8);
            check("held r", {24'd0, Remainder}, 2);
        end
        Start = 1'b0;
        @(posedge Clk);
        #1;
        check("release done", {31'd0, Done}, 0);
        @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
